rr_grant_scheduler: RTL

//   Sequential round-robin scheduler that shares one resource among N requesters.
//   It wraps a rotating-priority arbiter with a registered grant, a rotating priority

---
 rtl/rr_grant_scheduler_if.sv | 17 +
 rtl/rr_grant_scheduler.sv | 119 +++++++++++
 2 files changed

// File: rtl/rr_grant_scheduler_if.sv
// Requester/resource side of the round-robin scheduler: level requests and done in,
// registered one-hot grant, its index, a valid flag and the timeout pulse out.
interface rr_grant_scheduler_if #(
    parameter int N = 8
);
    localparam int ID_W = $clog2(N);

    logic [N-1:0]    req;
    logic            done;
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] gnt_id;
    logic            gnt_valid;
    logic            timeout;

    modport master (output req, done, input gnt, gnt_id, gnt_valid, timeout);
    modport slave  (input req, done, output gnt, gnt_id, gnt_valid, timeout);
endinterface

// File: rtl/rr_grant_scheduler.sv
// Round-robin scheduler sharing one resource among N requesters: registered one-hot
// grant, rotating priority pointer, back-to-back regrant and a hold timeout.
module rr_grant_scheduler #(
    parameter int N        = 8,
    parameter int HOLD_MAX = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_grant_scheduler_if.slave  bus
);
    localparam int ID_W  = $clog2(N);
    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = (HOLD_MAX > 0) ? CNT_W'(HOLD_MAX - 1) : '0;

    typedef enum logic {IDLE, GRANT} state_e;

    state_e          state_q, state_d;
    logic [N-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0] gnt_id_q, gnt_id_d;
    logic            gnt_valid_q, gnt_valid_d;
    logic            timeout_q, timeout_d;
    logic [N-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Lowest set candidate at or above ptr; if none, wrap to the lowest set candidate.
    function automatic logic [N-1:0] rr_pick(input logic [N-1:0] cand, input logic [N-1:0] ptr);
        logic [N-1:0] upper;
        upper = cand & ~(ptr - N'(1));
        if (|upper) return upper & (~upper + N'(1));
        return cand & (~cand + N'(1));
    endfunction

    function automatic logic [ID_W-1:0] to_id(input logic [N-1:0] oh);
        logic [ID_W-1:0] id;
        id = '0;
        for (int i = 0; i < N; i++) begin
            if (oh[i]) id = ID_W'(i);
        end
        return id;
    endfunction

    function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
        return {v[N-2:0], v[N-1]};
    endfunction

    logic [N-1:0] win;
    logic         abandon;
    logic         hold_exp;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        gnt_id_d  = gnt_id_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        win       = '0;
        abandon   = ~bus.req[gnt_id_q];
        hold_exp  = (HOLD_MAX != 0) && (cnt_q == HOLD_LAST);

        case (state_q)
            IDLE: begin
                if (|bus.req) begin
                    win      = rr_pick(bus.req, ptr_q);
                    gnt_d    = win;
                    gnt_id_d = to_id(win);
                    cnt_d    = '0;
                    state_d  = GRANT;
                end
            end
            GRANT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.done || abandon || hold_exp) begin
                    // The releasing requester drops to lowest priority and is excluded
                    // from the immediate rearbitration.
                    ptr_d     = rotl1(gnt_q);
                    win       = rr_pick(bus.req & ~gnt_q, ptr_d);
                    timeout_d = ~bus.done & ~abandon;
                    cnt_d     = '0;
                    if (|win) begin
                        gnt_d    = win;
                        gnt_id_d = to_id(win);
                    end else begin
                        gnt_d   = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        gnt_valid_d = |gnt_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            gnt_id_q    <= '0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            ptr_q       <= N'(1);
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            gnt_id_q    <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_id    = gnt_id_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.timeout   = timeout_q;
endmodule
